// File: rtl/ram_sp_arb.sv
// ============================================================================
// Module  : ram_sp_arb
// Round-robin multi-channel front end for one single-port RAM with tagged
// read responses. Optional per-channel stall counters:
// OPENEYE_RAM_ARB_STALL_CNT_EN
// Revision: 1.0
// ============================================================================
`default_nettype none

module ram_sp_arb #(
   parameter int CHANNELS        = 4,
   parameter int ADDR_WIDTH      = 10,
   parameter int DATA_WIDTH      = 32,
   parameter int PIPELINED       = 0,
   parameter int STALL_CNT_WIDTH = 16
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic [CHANNELS-1:0]            req_valid_i,
   output logic [CHANNELS-1:0]            req_ready_o,
   input  logic [CHANNELS-1:0]            req_we_i,
   input  logic [CHANNELS*ADDR_WIDTH-1:0] req_addr_i,
   input  logic [CHANNELS*DATA_WIDTH-1:0] req_data_i,
   output logic [CHANNELS-1:0]            rsp_valid_o,
   output logic [DATA_WIDTH-1:0]          rsp_data_o
`ifdef OPENEYE_RAM_ARB_STALL_CNT_EN
   ,
   output logic [CHANNELS*STALL_CNT_WIDTH-1:0] stall_cnt_o
`endif
);

   localparam int c_ch_w = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int c_lat  = 1 + PIPELINED;

   if (CHANNELS < 1 || STALL_CNT_WIDTH < 1 || PIPELINED < 0 || PIPELINED > 1) begin : g_param_check
      $error("ram_sp_arb: illegal parameter combination");
   end

   logic [c_ch_w-1:0]     r_ptr;
   logic [c_ch_w-1:0]     w_gnt_idx;
   logic                  w_gnt_vld;
   logic                  w_fire;
   logic [c_ch_w:0]       w_off;
   logic [c_ch_w:0]       w_best;
   logic                  w_rd_en;
   logic                  w_wr_en;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [DATA_WIDTH-1:0] w_wdata;

   // Winner is the valid channel with the smallest distance above the pointer.
   always_comb begin
      w_gnt_vld = 1'b0;
      w_gnt_idx = '0;
      w_best    = (c_ch_w+1)'(CHANNELS);
      w_off     = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         if ((c_ch_w+1)'(c) >= {1'b0, r_ptr}) begin
            w_off = (c_ch_w+1)'(c) - {1'b0, r_ptr};
         end else begin
            w_off = (c_ch_w+1)'(c + CHANNELS) - {1'b0, r_ptr};
         end
         if (req_valid_i[c] && (w_off < w_best)) begin
            w_best    = w_off;
            w_gnt_vld = 1'b1;
            w_gnt_idx = c_ch_w'(c);
         end
      end
   end

   assign w_fire  = w_gnt_vld & ~rst_i;
   assign w_rd_en = w_fire & ~req_we_i[w_gnt_idx];
   assign w_wr_en = w_fire &  req_we_i[w_gnt_idx];
   assign w_addr  = req_addr_i[w_gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
   assign w_wdata = req_data_i[w_gnt_idx*DATA_WIDTH +: DATA_WIDTH];

   always_comb begin
      req_ready_o = '0;
      if (w_fire) begin
         req_ready_o[w_gnt_idx] = 1'b1;
      end
   end

   if (CHANNELS > 1) begin : g_ptr_rr
      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            r_ptr <= '0;
         end else if (w_fire) begin
            r_ptr <= (w_gnt_idx == c_ch_w'(CHANNELS-1)) ? '0 : w_gnt_idx + 1'b1;
         end
      end
   end else begin : g_ptr_const
      assign r_ptr = '0;
   end

   // Memory array plus read-data pipeline; contents are deliberately not reset.
   logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
   logic [DATA_WIDTH-1:0] r_rd_data [c_lat];

   always_ff @(posedge clk_i) begin
      if (w_wr_en) begin
         r_mem[w_addr] <= w_wdata;
      end
      if (w_rd_en) begin
         r_rd_data[0] <= r_mem[w_addr];
      end
      for (int i = 1; i < c_lat; i++) begin
         r_rd_data[i] <= r_rd_data[i-1];
      end
   end

   // Tag pipeline travels alongside the read data so responses stay in order.
   logic [c_lat-1:0]  r_tag_vld;
   logic [c_ch_w-1:0] r_tag_ch [c_lat];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_tag_vld <= '0;
      end else begin
         r_tag_vld[0] <= w_rd_en;
         for (int i = 1; i < c_lat; i++) begin
            r_tag_vld[i] <= r_tag_vld[i-1];
         end
      end
      r_tag_ch[0] <= w_gnt_idx;
      for (int i = 1; i < c_lat; i++) begin
         r_tag_ch[i] <= r_tag_ch[i-1];
      end
   end

   always_comb begin
      rsp_valid_o = '0;
      if (r_tag_vld[c_lat-1]) begin
         rsp_valid_o[r_tag_ch[c_lat-1]] = 1'b1;
      end
   end

   assign rsp_data_o = r_rd_data[c_lat-1];

`ifdef OPENEYE_RAM_ARB_STALL_CNT_EN
   for (genvar c = 0; c < CHANNELS; c++) begin : g_stall
      logic [STALL_CNT_WIDTH-1:0] r_cnt;
      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            r_cnt <= '0;
         end else if (req_valid_i[c] && !req_ready_o[c] && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
      assign stall_cnt_o[c*STALL_CNT_WIDTH +: STALL_CNT_WIDTH] = r_cnt;
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_ram_sp_arb.sv
// ============================================================================
// Module  : tb_ram_sp_arb
// Scoreboard bench for ram_sp_arb; one 1-cycle and one 2-cycle instance share
// stimulus. Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ram_sp_arb;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   v, we;
   logic [39:0]  addr;
   logic [127:0] data;
   logic [3:0]   rdy0, rdy1, rv0, rv1;
   logic [31:0]  rd0, rd1;
   logic [63:0]  st0;
   logic [7:0]   st1;

   always #5 clk = ~clk;

   ram_sp_arb #(.CHANNELS(4), .ADDR_WIDTH(10), .DATA_WIDTH(32), .PIPELINED(0), .STALL_CNT_WIDTH(16)) u_dut0 (
      .clk_i(clk), .rst_i(rst), .req_valid_i(v), .req_ready_o(rdy0), .req_we_i(we),
      .req_addr_i(addr), .req_data_i(data), .rsp_valid_o(rv0), .rsp_data_o(rd0)
`ifdef OPENEYE_RAM_ARB_STALL_CNT_EN
      , .stall_cnt_o(st0)
`endif
   );

   ram_sp_arb #(.CHANNELS(4), .ADDR_WIDTH(10), .DATA_WIDTH(32), .PIPELINED(1), .STALL_CNT_WIDTH(2)) u_dut1 (
      .clk_i(clk), .rst_i(rst), .req_valid_i(v), .req_ready_o(rdy1), .req_we_i(we),
      .req_addr_i(addr), .req_data_i(data), .rsp_valid_o(rv1), .rsp_data_o(rd1)
`ifdef OPENEYE_RAM_ARB_STALL_CNT_EN
      , .stall_cnt_o(st1)
`endif
   );

   typedef struct {logic we; logic [9:0] addr; logic [31:0] data;} req_t;
   typedef struct {int ch; logic [31:0] data; int due;} exp_t;

   req_t        rq[4][$];
   exp_t        sb[2][$];
   logic [31:0] mem_model [1024];
   int          cyc = 0;
   int          tb_ptr = 0;
   int          wt[4];
   int          st16[4];
   int          st2[4];
   int          n_cmp = 0;
   int          n_err = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic check_rsp(input int k, input logic [3:0] rv, input logic [31:0] rd);
      exp_t e;
      if (rv != 4'b0) begin
         if (sb[k].size() == 0) begin
            check_val($sformatf("rsp_unexp%0d", k), 64'(rv), 64'd0);
         end else begin
            e = sb[k].pop_front();
            check_val($sformatf("rsp_ch%0d", k), 64'(rv), 64'(4'b1 << e.ch));
            check_val($sformatf("rsp_data%0d", k), 64'(rd), 64'(e.data));
            check_val($sformatf("rsp_lat%0d", k), 64'(cyc), 64'(e.due));
         end
      end else if (sb[k].size() > 0 && sb[k][0].due <= cyc) begin
         e = sb[k].pop_front();
         check_val($sformatf("rsp_miss%0d", k), 64'(rv), 64'(4'b1 << e.ch));
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Requesters present the head of their queue until it is granted.
   always @(posedge clk) begin
      #1;
      for (int c = 0; c < 4; c++) begin
         if (rq[c].size() > 0) begin
            v[c]             = 1'b1;
            we[c]            = rq[c][0].we;
            addr[c*10 +: 10] = rq[c][0].addr;
            data[c*32 +: 32] = rq[c][0].data;
         end else begin
            v[c]  = 1'b0;
            we[c] = 1'b0;
         end
      end
   end

   // Reference arbiter, memory and response scoreboard.
   always @(negedge clk) begin
      int g;
      int cc;
      logic [3:0] exp_rdy;
      if (rst) begin
         check_val("ready_in_reset", 64'(rdy0 | rdy1), 64'd0);
         sb[0].delete();
         sb[1].delete();
         tb_ptr = 0;
         for (int c = 0; c < 4; c++) begin
            wt[c] = 0; st16[c] = 0; st2[c] = 0;
         end
      end else begin
         check_rsp(0, rv0, rd0);
         check_rsp(1, rv1, rd1);
         g = -1;
         for (int i = 0; i < 4; i++) begin
            cc = (tb_ptr + i) % 4;
            if (v[cc] && g < 0) g = cc;
         end
         exp_rdy = (g >= 0) ? (4'b1 << g) : 4'b0;
         check_val("ready0", 64'(rdy0), 64'(exp_rdy));
         check_val("ready1", 64'(rdy1), 64'(exp_rdy));
`ifdef OPENEYE_RAM_ARB_STALL_CNT_EN
         for (int c = 0; c < 4; c++) begin
            check_val($sformatf("stall16_ch%0d", c), 64'(st0[c*16 +: 16]), 64'(st16[c]));
            check_val($sformatf("stall2_ch%0d", c), 64'(st1[c*2 +: 2]), 64'(st2[c]));
         end
`endif
         for (int c = 0; c < 4; c++) begin
            if (v[c] && c != g) begin
               wt[c]++;
               if (st16[c] < 65535) st16[c]++;
               if (st2[c] < 3) st2[c]++;
            end
         end
         if (g >= 0) begin
            check_val("fair_wait", 64'(wt[g] <= 3), 64'd1);
            wt[g] = 0;
            if (we[g]) begin
               mem_model[addr[g*10 +: 10]] = data[g*32 +: 32];
            end else begin
               sb[0].push_back('{ch: g, data: mem_model[addr[g*10 +: 10]], due: cyc + 1});
               sb[1].push_back('{ch: g, data: mem_model[addr[g*10 +: 10]], due: cyc + 2});
            end
            void'(rq[g].pop_front());
            tb_ptr = (g + 1) % 4;
         end
      end
   end

   function automatic int pending();
      return rq[0].size() + rq[1].size() + rq[2].size() + rq[3].size()
           + sb[0].size() + sb[1].size();
   endfunction

   task automatic wait_idle(input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk); #1;
         if (pending() == 0) return;
      end
      check_val("timeout", 64'(pending()), 64'd0);
   endtask

   task automatic push(input int c, input logic w, input logic [9:0] a, input logic [31:0] d);
      rq[c].push_back('{we: w, addr: a, data: d});
   endtask

   task automatic do_reset(input int n);
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (n) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      rst  = 1'b1;
      v    = '0;
      we   = '0;
      addr = '0;
      data = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_val("rsp_after_reset", 64'(rv0 | rv1), 64'd0);

      // Preload addresses 0..15.
      for (int a = 0; a < 16; a++) push(0, 1'b1, 10'(a), (a < 4) ? 32'(10 + a) : 32'(100 + a));
      wait_idle(100);

      // Back-to-back reads on ch0.
      for (int a = 0; a < 4; a++) push(0, 1'b0, 10'(a), 32'd0);
      wait_idle(50);

      // Single write then read on different channels.
      push(2, 1'b1, 10'd5, 32'hDEADBEEF);
      wait_idle(50);
      push(1, 1'b0, 10'd5, 32'd0);
      wait_idle(50);

      // Write on ch3, then read of the same address one cycle later.
      push(3, 1'b1, 10'd7, 32'h55);
      wait_idle(50);
      push(0, 1'b0, 10'd7, 32'd0);
      wait_idle(50);

      // Round-robin from reset, all channels continuously valid.
      do_reset(2);
      for (int k = 0; k < 2; k++)
         for (int c = 0; c < 4; c++) push(c, 1'b0, 10'(c), 32'd0);
      wait_idle(100);

      // Reset while a pipelined read is in flight.
      @(negedge clk); #1;
      push(1, 1'b0, 10'd1, 32'd0);
      for (int i = 0; i < 20 && rq[1].size() > 0; i++) begin
         @(negedge clk); #1;
      end
      check_val("flight_grant", 64'(rq[1].size()), 64'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk); #1;
      push(2, 1'b0, 10'd2, 32'd0);
      push(0, 1'b0, 10'd0, 32'd0);
      wait_idle(50);

      // Mixed random traffic.
      for (int k = 0; k < 40; k++) begin
         push(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              10'($urandom_range(0, 15)), $urandom);
      end
      wait_idle(400);
      repeat (5) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
